// File: rtl/sampler_pkg.sv
// Shared types and helpers for the candidate sampler.
// Holds the FSM state set, the LFSR tap mask and beat sizing.
package sampler_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_CHECK = 3'd2,
    S_OFFER = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

  function automatic int fill_beats(input int w);
    return (w + 31) / 32;
  endfunction

  function automatic logic [31:0] lfsr_step(
    input logic [31:0] x
  );
    logic [31:0] r;
    r = x >> 1;
    if (x[0]) r = r ^ LFSR_MASK;
    return r;
  endfunction

endpackage

// File: rtl/lfsr32.sv
// 32-bit Galois LFSR with seed load and step enable.
// A zero seed is replaced by DEF_SEED so the LFSR never locks up.
module lfsr32
  import sampler_pkg::*;
#(
  parameter logic [31:0] DEF_SEED = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        step,
  output logic [31:0] q
);

  logic [31:0] q_q;
  logic [31:0] q_d;

  // next state: load wins over step
  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = (seed == 32'h0) ? DEF_SEED : seed;
    end else if (step) begin
      q_d = lfsr_step(q_q);
    end
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= DEF_SEED;
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/candidate_sampler.sv
// Rejection sampler: fills random candidates from an LFSR,
// keeps those the external checker accepts, streams them out.
module candidate_sampler
  import sampler_pkg::*;
#(
  parameter int          VEC_W     = 394,
  parameter int          MAX_TRIES = 1024,
  parameter logic [31:0] DEF_SEED  = 32'h0000_0001
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             seed_load,
  input  logic [31:0]      seed,
  input  logic [15:0]      num_samples,
  output logic [VEC_W-1:0] cand_o,
  input  logic             sat_i,
  output logic             sample_valid,
  input  logic             sample_ready,
  output logic [VEC_W-1:0] sample_data,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [31:0]      tries_cnt,
  output logic [15:0]      hits_cnt
);

  localparam int FILL_BEATS = fill_beats(VEC_W);
  localparam logic [15:0] LAST_BEAT =
    16'(FILL_BEATS - 1);
  localparam logic [31:0] MAX_T = 32'(MAX_TRIES);

  state_e           state_q, state_d;
  logic [VEC_W-1:0] cand_q, cand_d;
  logic [15:0]      beat_q, beat_d;
  logic [31:0]      tries_q, tries_d;
  logic [15:0]      hits_q, hits_d;
  logic [31:0]      fail_q, fail_d;
  logic [15:0]      num_q, num_d;
  logic             to_q, to_d;

  logic             lfsr_load;
  logic             lfsr_step_en;
  logic [31:0]      lfsr_q;

  lfsr32 #(
    .DEF_SEED (DEF_SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (lfsr_load),
    .seed  (seed),
    .step  (lfsr_step_en),
    .q     (lfsr_q)
  );

  // FSM next state and datapath updates
  always_comb begin
    state_d      = state_q;
    cand_d       = cand_q;
    beat_d       = beat_q;
    tries_d      = tries_q;
    hits_d       = hits_q;
    fail_d       = fail_q;
    num_d        = num_q;
    to_d         = to_q;
    lfsr_load    = 1'b0;
    lfsr_step_en = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        lfsr_load = seed_load;
        if (start) begin
          tries_d = 32'h0;
          hits_d  = 16'h0;
          fail_d  = 32'h0;
          to_d    = 1'b0;
          beat_d  = 16'h0;
          num_d   = num_samples;
          state_d = (num_samples == 16'h0) ?
                    S_DONE : S_FILL;
        end
      end
      S_FILL: begin
        // beat shifted in is the LFSR's new value
        lfsr_step_en = 1'b1;
        cand_d = {cand_q[VEC_W-33:0],
                  lfsr_step(lfsr_q)};
        beat_d = beat_q + 16'd1;
        if (beat_q == LAST_BEAT) begin
          beat_d  = 16'h0;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (tries_q != 32'hFFFF_FFFF)
          tries_d = tries_q + 32'd1;
        if (sat_i) begin
          fail_d  = 32'h0;
          state_d = S_OFFER;
        end else begin
          fail_d = fail_q + 32'd1;
          if (fail_q + 32'd1 >= MAX_T) begin
            to_d    = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_FILL;
          end
        end
      end
      S_OFFER: begin
        if (sample_ready) begin
          hits_d  = hits_q + 16'd1;
          state_d = (hits_q + 16'd1 == num_q) ?
                    S_DONE : S_FILL;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cand_q  <= '0;
      beat_q  <= 16'h0;
      tries_q <= 32'h0;
      hits_q  <= 16'h0;
      fail_q  <= 32'h0;
      num_q   <= 16'h0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      beat_q  <= beat_d;
      tries_q <= tries_d;
      hits_q  <= hits_d;
      fail_q  <= fail_d;
      num_q   <= num_d;
      to_q    <= to_d;
    end
  end

  assign cand_o       = cand_q;
  assign sample_data  = cand_q;
  assign sample_valid = (state_q == S_OFFER);
  assign busy         = (state_q == S_FILL)  ||
                        (state_q == S_CHECK) ||
                        (state_q == S_OFFER);
  assign done         = (state_q == S_DONE);
  assign timeout      = to_q;
  assign tries_cnt    = tries_q;
  assign hits_cnt     = hits_q;

endmodule
